// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// bit positions and the digit-index width helper.
package seg7_pkg;

   typedef logic [7:0] seg_t;

   // Bit 7 is the decimal point; bits 6..0 are segments a..g, active-high.
   localparam int   DP_BIT    = 7;
   localparam seg_t SEG_BLANK = 8'h00;

   localparam seg_t SEG_0 = 8'b0111_1110;
   localparam seg_t SEG_1 = 8'b0011_0000;
   localparam seg_t SEG_2 = 8'b0110_1101;
   localparam seg_t SEG_3 = 8'b0111_1001;
   localparam seg_t SEG_4 = 8'b0011_0011;
   localparam seg_t SEG_5 = 8'b0101_1011;
   localparam seg_t SEG_6 = 8'b0101_1111;
   localparam seg_t SEG_7 = 8'b0111_0000;
   localparam seg_t SEG_8 = 8'b0111_1111;
   localparam seg_t SEG_9 = 8'b0111_1011;
   localparam seg_t SEG_A = 8'b0111_0111;
   localparam seg_t SEG_B = 8'b0001_1111;
   localparam seg_t SEG_C = 8'b0100_1110;
   localparam seg_t SEG_D = 8'b0011_1101;
   localparam seg_t SEG_E = 8'b0100_1111;
   localparam seg_t SEG_F = 8'b0100_0111;

   // Width of the digit index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Datapath-side and display-side signals of the scan driver.
//
// Signalling: there is no valid/ready pair. load is a one-cycle strobe
// sampled on every rising clk edge and is always accepted (the pending
// buffer simply takes the newest value). enable is a level. All outputs
// are registered and change only on rising clk edges or async reset.
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      enable;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   din;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic                      blank_lz;
   logic [7:0]                seg_out;
   logic [NUM_DIGITS-1:0]     dig_sel;
   logic                      frame_done;

   modport master (
      output enable, load, din, dp_in, blank_lz,
      input  seg_out, dig_sel, frame_done
   );

   modport slave (
      input  enable, load, din, dp_in, blank_lz,
      output seg_out, dig_sel, frame_done
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit decoder: 4-bit code to segment pattern with dp,
// optional hex letters and a blanking override for leading zeros.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       dp,
   input  logic       blank,
   input  logic       hex_en,
   output seg_t       pattern
);

   // Table lookup, then blanking clears a..g only; dp always passes through.
   always_comb begin
      pattern = SEG_BLANK;
      case (code)
         4'h0: pattern = SEG_0;
         4'h1: pattern = SEG_1;
         4'h2: pattern = SEG_2;
         4'h3: pattern = SEG_3;
         4'h4: pattern = SEG_4;
         4'h5: pattern = SEG_5;
         4'h6: pattern = SEG_6;
         4'h7: pattern = SEG_7;
         4'h8: pattern = SEG_8;
         4'h9: pattern = SEG_9;
         4'hA: pattern = hex_en ? SEG_A : SEG_BLANK;
         4'hB: pattern = hex_en ? SEG_B : SEG_BLANK;
         4'hC: pattern = hex_en ? SEG_C : SEG_BLANK;
         4'hD: pattern = hex_en ? SEG_D : SEG_BLANK;
         4'hE: pattern = hex_en ? SEG_E : SEG_BLANK;
         default: pattern = hex_en ? SEG_F : SEG_BLANK;
      endcase
      if (blank) pattern[6:0] = 7'b0;
      pattern[DP_BIT] = dp;
   end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed N-digit seven-segment scan driver with a double-buffered
// digit value, programmable per-digit dwell and leading-zero blanking.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int HEX_MODE   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   seg7_scan_if.slave bus
);

   localparam int                  IW       = idx_width(NUM_DIGITS);
   localparam int                  CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]       CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]       IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

   logic [CW-1:0]                 cnt;
   logic [IW-1:0]                 idx;
   logic [NUM_DIGITS-1:0][3:0]    disp_code;
   logic [NUM_DIGITS-1:0][3:0]    pend_code;
   logic [NUM_DIGITS-1:0]         disp_dp;
   logic [NUM_DIGITS-1:0]         pend_dp;
   logic                          pend_valid;
   logic                          wrap_pend;
   logic                          cnt_last;
   logic                          wrap;
   logic [NUM_DIGITS-1:0]         lz_run;
   logic                          lz_blank;
   logic [NUM_DIGITS-1:0]         sel_next;
   seg_t                          pattern;

   // Terminal count only counts while scanning; wrap is the last dwell
   // cycle of the most significant digit.
   assign cnt_last = bus.enable && (cnt == CNT_LAST);
   assign wrap     = cnt_last && (idx == IDX_LAST);
   assign sel_next = SEL_ONE << idx;

   // lz_run[k]: digit k and every more significant digit hold code 0.
   always_comb begin
      lz_run = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= k) && (disp_code[j] != 4'h0)) lz_run[k] = 1'b0;
         end
      end
   end

   // Digit 0 is never blanked so an all-zero value still shows "0".
   assign lz_blank = bus.blank_lz && (idx != '0) && lz_run[idx];

   seg7_decode u_decode (
      .code    (disp_code[idx]),
      .dp      (disp_dp[idx]),
      .blank   (lz_blank),
      .hex_en  (HEX_MODE != 0),
      .pattern (pattern)
   );

   // Prescaler and digit index; both freeze while enable is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (bus.enable) begin
         cnt <= cnt_last ? '0 : cnt + 1'b1;
         if (cnt_last) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Double buffer: loads land in pending, pending moves to display only
   // at a wrap, so a frame never mixes two loads. A load coinciding with
   // the wrap bypasses pending and is shown in the frame starting then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_code  <= '0;
         disp_dp    <= '0;
         pend_code  <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else if (bus.load && wrap) begin
         disp_code  <= bus.din;
         disp_dp    <= bus.dp_in;
         pend_valid <= 1'b0;
      end else if (bus.load) begin
         pend_code  <= bus.din;
         pend_dp    <= bus.dp_in;
         pend_valid <= 1'b1;
      end else if (wrap && pend_valid) begin
         disp_code  <= pend_code;
         disp_dp    <= pend_dp;
         pend_valid <= 1'b0;
      end
   end

   // Remembers a wrap until the first enabled output update, so frame_done
   // lines up with the first registered select of digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          wrap_pend <= 1'b0;
      else if (wrap)       wrap_pend <= 1'b1;
      else if (bus.enable) wrap_pend <= 1'b0;
   end

   // Registered display outputs, one cycle behind index/display state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg_out    <= SEG_BLANK;
         bus.dig_sel    <= '0;
         bus.frame_done <= 1'b0;
      end else if (bus.enable) begin
         bus.seg_out    <= pattern;
         bus.dig_sel    <= sel_next;
         bus.frame_done <= wrap_pend;
      end else begin
         bus.seg_out    <= SEG_BLANK;
         bus.dig_sel    <= '0;
         bus.frame_done <= 1'b0;
      end
   end

endmodule
